// File: rtl/mem_nibble_responder.sv
// mem_nibble_responder: memory-side endpoint for the DMA 4-bit memory port.
// Accepts an address/length command, then absorbs (write) or sources (read)
// a low-nibble-first stream against a byte-wide storage array.
// Optional feature macro: MEM_NIBBLE_RESP_CHECKSUM_EN enables a running
// mod-256 byte checksum of the current/last command; otherwise checksum is 0.
module mem_nibble_responder #(
   parameter int AW = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mode,
   input  logic        addr_in_valid,
   output logic        addr_in_enable,
   input  logic [31:0] addr_in,
   input  logic [31:0] len_in,
   input  logic        dma_to_mem_valid,
   output logic        dma_to_mem_enable,
   input  logic [3:0]  mem_in_socket,
   output logic        mem_to_dma_valid,
   input  logic        mem_to_dma_enable,
   output logic [3:0]  mem_out_socket,
   output logic        busy,
   output logic        done,
   output logic [7:0]  checksum
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state;
   state_t        state_next;
   logic [AW-1:0] ptr;
   logic [31:0]   cnt;
   logic          half;
   logic          dir;
   logic [3:0]    hold;
   logic [7:0]    mem [2**AW];

   logic          cmd_fire;
   logic          wr_fire;
   logic          rd_fire;
   logic          byte_fire;
   logic          last_byte;
   logic [7:0]    rd_byte;
   logic [7:0]    wr_byte;

   // Upper address bits are deliberately ignored; storage wraps modulo 2^AW.
   logic          unused_addr_bits;
   assign unused_addr_bits = ^addr_in[31:AW];

   assign rd_byte = mem[ptr];
   assign wr_byte = {mem_in_socket, hold};

   // Decode outputs from the state, derive handshakes and choose the next state.
   always_comb begin
      state_next        = state;
      addr_in_enable    = 1'b0;
      dma_to_mem_enable = 1'b0;
      mem_to_dma_valid  = 1'b0;
      mem_out_socket    = 4'h0;
      busy              = 1'b0;
      done              = 1'b0;
      if (!reset) begin
         case (state)
            IDLE: addr_in_enable = 1'b1;
            XFER: begin
               busy = 1'b1;
               if (dir) begin
                  dma_to_mem_enable = 1'b1;
               end else begin
                  mem_to_dma_valid = 1'b1;
                  mem_out_socket   = half ? rd_byte[7:4] : rd_byte[3:0];
               end
            end
            DONE: begin
               busy = 1'b1;
               done = 1'b1;
            end
            default: ;
         endcase
      end
      cmd_fire  = addr_in_enable & addr_in_valid;
      wr_fire   = dma_to_mem_enable & dma_to_mem_valid;
      rd_fire   = mem_to_dma_valid & mem_to_dma_enable;
      byte_fire = (wr_fire | rd_fire) & half;
      last_byte = byte_fire & (cnt == 32'd1);
      case (state)
         IDLE: begin
            if (cmd_fire) begin
               state_next = (len_in == 32'd0) ? DONE : XFER;
            end
         end
         XFER: begin
            if (last_byte) begin
               state_next = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State register; reset always returns to IDLE and drops any command.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Command parameters, byte pointer, remaining count and nibble phase.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr  <= '0;
         cnt  <= 32'd0;
         half <= 1'b0;
         hold <= 4'h0;
         dir  <= 1'b0;
      end else if (cmd_fire) begin
         ptr  <= addr_in[AW-1:0];
         cnt  <= len_in;
         dir  <= mode;
         half <= 1'b0;
      end else if (wr_fire || rd_fire) begin
         half <= ~half;
         if (wr_fire && !half) begin
            hold <= mem_in_socket;
         end
         if (half) begin
            ptr <= ptr + AW'(1);
            cnt <= cnt - 32'd1;
         end
      end
   end

   // Storage write on the high-nibble handshake; contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_fire && half) begin
         mem[ptr] <= wr_byte;
      end
   end

`ifdef MEM_NIBBLE_RESP_CHECKSUM_EN
   logic [7:0] sum;

   // Running byte sum, cleared at command accept and frozen once the command ends.
   always_ff @(posedge clk) begin
      if (reset) begin
         sum <= 8'h00;
      end else if (cmd_fire) begin
         sum <= 8'h00;
      end else if (byte_fire) begin
         sum <= sum + (dir ? wr_byte : rd_byte);
      end
   end

   assign checksum = sum;
`else
   assign checksum = 8'h00;
`endif

endmodule
